lcd_timing_pattern_gen: RTL and testbench

Parametrised LCD/VGA timing generator with a built-in multi-mode test-pattern source. It is the generalised successor of the fixed 480x272 colour-bar generator. Timing geometry, sync polarities and pixel width are parameters, and the pattern mode is selectable at runtime. It drives panel timing directly, or provides hs/vs/de/active_x/active_y to the SDRAM frame-read path when the pattern is unused.

---
 rtl/lcd_timing_pattern_gen.sv | 183 ++++++++++++++++++
 tb/tb_lcd_timing_pattern_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_pattern_gen.sv
// Parametrised LCD/VGA timing generator with runtime-selectable test patterns.
// Optional build macro PATTERN_SCROLL_EN: per-frame horizontal scroll of modes 0 and 2.
module lcd_timing_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 480,
  parameter int unsigned H_FP      = 2,
  parameter int unsigned H_SYNC    = 41,
  parameter int unsigned H_BP      = 2,
  parameter int unsigned V_ACTIVE  = 272,
  parameter int unsigned V_FP      = 2,
  parameter int unsigned V_SYNC    = 10,
  parameter int unsigned V_BP      = 2,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned CW        = 8,
  parameter int unsigned GRID_LOG2 = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] solid_rgb,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic [CW-1:0]   rgb_r,
  output logic [CW-1:0]   rgb_g,
  output logic [CW-1:0]   rgb_b,
  output logic [11:0]     active_x,
  output logic [11:0]     active_y,
  output logic            frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_SYNC_W   = 12'(H_SYNC);
  localparam logic [11:0] H_ACT_BEG  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_END  = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] H_ACT_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_SYNC_W   = 12'(V_SYNC);
  localparam logic [11:0] V_ACT_BEG  = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_END  = 12'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] V_ACT_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] BAR_W      = 12'(H_ACTIVE / 8);
  localparam logic [CW-1:0] FULL     = {CW{1'b1}};

  if (H_ACTIVE < 8 || H_TOTAL > 4096 || V_TOTAL > 4096 || H_FP < 1 || H_SYNC < 1 ||
      H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || V_ACTIVE < 1 || CW < 1 ||
      CW > 12 || GRID_LOG2 < 1) begin : g_param_err
    $error("lcd_timing_pattern_gen: illegal parameter set");
  end

  logic [11:0]     h_q, h_d, v_q, v_d;
  logic [1:0]      mode_q, mode_d;
  logic [3*CW-1:0] solid_q, solid_d;
  logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [CW-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic [11:0]     ax_q, ax_d, ay_q, ay_d;
  logic            frame_top_s, h_act_s, v_act_s;
  logic [11:0]     x_pat_s, bar_q12_s;
  logic [2:0]      bar_idx_s, bar_rgb_s;
  logic            grid_on_s;

  // Counter advance, frame-boundary latching of mode/colour and timing decode.
  always_comb begin
    frame_top_s = (h_q == 12'd0) && (v_q == 12'd0);
    h_d = (h_q == H_LAST) ? 12'd0 : h_q + 12'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
    end else begin
      v_d = v_q;
    end
    mode_d  = frame_top_s ? mode : mode_q;
    solid_d = frame_top_s ? solid_rgb : solid_q;
    h_act_s = (h_q >= H_ACT_BEG) && (h_q < H_ACT_END);
    v_act_s = (v_q >= V_ACT_BEG) && (v_q < V_ACT_END);
    hs_d = (h_q < H_SYNC_W) ? HS_POL : ~HS_POL;
    vs_d = (v_q < V_SYNC_W) ? VS_POL : ~VS_POL;
    de_d = h_act_s && v_act_s;
    fs_d = frame_top_s;
    ax_d = de_d ? h_q - H_ACT_BEG : 12'd0;
    ay_d = de_d ? v_q - V_ACT_BEG : 12'd0;
  end

`ifdef PATTERN_SCROLL_EN
  logic [11:0] fc_q, fc_d;
  logic [12:0] x_sum_s;

  // Frame counter and scrolled pattern column.
  always_comb begin
    fc_d    = frame_top_s ? fc_q + 12'd1 : fc_q;
    x_sum_s = {1'b0, ax_d} + {1'b0, fc_q};
    x_pat_s = 12'(x_sum_s % 13'(H_ACTIVE));
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fc_q <= 12'd0;
    end else begin
      fc_q <= fc_d;
    end
  end
`else
  assign x_pat_s = ax_d;
`endif

  // Pattern generation; the last colour bar absorbs the division remainder.
  always_comb begin
    bar_q12_s = x_pat_s / BAR_W;
    bar_idx_s = (bar_q12_s > 12'd7) ? 3'd7 : bar_q12_s[2:0];
    case (bar_idx_s)
      3'd0:    bar_rgb_s = 3'b111;
      3'd1:    bar_rgb_s = 3'b110;
      3'd2:    bar_rgb_s = 3'b011;
      3'd3:    bar_rgb_s = 3'b010;
      3'd4:    bar_rgb_s = 3'b101;
      3'd5:    bar_rgb_s = 3'b100;
      3'd6:    bar_rgb_s = 3'b001;
      default: bar_rgb_s = 3'b000;
    endcase
    grid_on_s = (ax_d[GRID_LOG2-1:0] == {GRID_LOG2{1'b0}}) ||
                (ay_d[GRID_LOG2-1:0] == {GRID_LOG2{1'b0}}) ||
                (ax_d == H_ACT_LAST) || (ay_d == V_ACT_LAST);
    r_d = {CW{1'b0}};
    g_d = {CW{1'b0}};
    b_d = {CW{1'b0}};
    if (de_d) begin
      case (mode_d)
        2'd0: begin
          r_d = bar_rgb_s[2] ? FULL : {CW{1'b0}};
          g_d = bar_rgb_s[1] ? FULL : {CW{1'b0}};
          b_d = bar_rgb_s[0] ? FULL : {CW{1'b0}};
        end
        2'd1: begin
          r_d = grid_on_s ? FULL : {CW{1'b0}};
          g_d = grid_on_s ? FULL : {CW{1'b0}};
          b_d = grid_on_s ? FULL : {CW{1'b0}};
        end
        2'd2: begin
          r_d = x_pat_s[CW-1:0];
          g_d = x_pat_s[CW-1:0];
          b_d = x_pat_s[CW-1:0];
        end
        default: {r_d, g_d, b_d} = solid_d;
      endcase
    end else begin
      r_d = {CW{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q <= 12'd0;       v_q <= 12'd0;
      mode_q <= 2'd0;     solid_q <= {3*CW{1'b0}};
      hs_q <= ~HS_POL;    vs_q <= ~VS_POL;
      de_q <= 1'b0;       fs_q <= 1'b0;
      r_q <= {CW{1'b0}};  g_q <= {CW{1'b0}};  b_q <= {CW{1'b0}};
      ax_q <= 12'd0;      ay_q <= 12'd0;
    end else begin
      h_q <= h_d;         v_q <= v_d;
      mode_q <= mode_d;   solid_q <= solid_d;
      hs_q <= hs_d;       vs_q <= vs_d;
      de_q <= de_d;       fs_q <= fs_d;
      r_q <= r_d;         g_q <= g_d;         b_q <= b_d;
      ax_q <= ax_d;       ay_q <= ay_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign rgb_r       = r_q;
  assign rgb_g       = g_q;
  assign rgb_b       = b_q;
  assign active_x    = ax_q;
  assign active_y    = ay_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Self-checking bench for lcd_timing_pattern_gen on a reduced 27x12 geometry:
// cycle-by-cycle scoreboard, a table of pattern pixels and hand-written corner sequences.
module tb_lcd_timing_pattern_gen;

  localparam int HA = 20, HFP = 2, HSY = 3, HBP = 2;
  localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HSY + HBP + HA + HFP;   // 27
  localparam int VT = VSY + VBP + VA + VFP;   // 12
  localparam int FRAME = HT * VT;             // 324

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic        hs, vs, de, frame_start;
  logic [7:0]  rgb_r, rgb_g, rgb_b;
  logic [11:0] active_x, active_y;

  lcd_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(8), .GRID_LOG2(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb),
    .hs(hs), .vs(vs), .de(de), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .active_x(active_x), .active_y(active_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic hs, vs, de;
    logic [7:0] r, g, b;
    logic [11:0] ax, ay;
    logic fs;
  } out_t;

  typedef struct {
    logic [1:0]  m;
    logic [23:0] s;
    int          x, y;
    logic [23:0] exp;
  } vec_t;

  out_t exp_q[$];
  vec_t tbl[$];
  int vec_cnt = 0, miss_cnt = 0;

  function automatic logic [23:0] bar_colour(int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic out_t model(int h, int v, logic [1:0] m, logic [23:0] s, int fc);
    out_t o;
    int x, y, xp, bi;
    o = '0;
    o.hs = (h < HSY) ? 1'b0 : 1'b1;
    o.vs = (v < VSY) ? 1'b1 : 1'b0;
    o.fs = (h == 0) && (v == 0);
    o.de = (h >= HSY + HBP) && (h < HSY + HBP + HA) && (v >= VSY + VBP) && (v < VSY + VBP + VA);
    if (o.de) begin
      x = h - (HSY + HBP);
      y = v - (VSY + VBP);
      o.ax = 12'(x);
      o.ay = 12'(y);
      xp = x;
`ifdef PATTERN_SCROLL_EN
      xp = (x + fc) % HA;
`endif
      case (m)
        2'd0: begin
          bi = xp / (HA / 8);
          if (bi > 7) bi = 7;
          {o.r, o.g, o.b} = bar_colour(bi);
        end
        2'd1: begin
          if ((x % 4 == 0) || (y % 4 == 0) || (x == HA - 1) || (y == VA - 1))
            {o.r, o.g, o.b} = 24'hFFFFFF;
        end
        2'd2: begin
          o.r = 8'(xp % 256); o.g = 8'(xp % 256); o.b = 8'(xp % 256);
        end
        default: {o.r, o.g, o.b} = s;
      endcase
    end
    return o;
  endfunction

  // Cycle-accurate scoreboard: expectation pushed at each edge, compared just after it.
  initial begin : scoreboard
    int mh = 0, mv = 0, mfc = 0;
    logic [1:0] mm = 2'd0;
    logic [23:0] ms = 24'h0;
    out_t e, g;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mh = 0; mv = 0; mm = 2'd0; ms = 24'h0; mfc = 0;
        e = '0; e.hs = 1'b1; e.vs = 1'b0;
      end else begin
        if (mh == 0 && mv == 0) begin
          mm = mode; ms = solid_rgb; mfc = (mfc + 1) % 4096;
        end
        e = model(mh, mv, mm, ms, mfc);
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      g = '{hs, vs, de, rgb_r, rgb_g, rgb_b, active_x, active_y, frame_start};
      vec_cnt++;
      if (g !== e) begin
        miss_cnt++;
        $display("FAIL sb t=%0t got %h want %h", $time, g, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      miss_cnt++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin tick(); n++; end while (!frame_start && n < 2 * FRAME);
    chk("wait_frame_start", {31'd0, frame_start}, 32'd1);
  endtask

  task automatic wait_px(input int x, input int y);
    int n = 0;
    while (!(de && active_x == 12'(x) && active_y == 12'(y)) && n < 2 * FRAME) begin
      tick(); n++;
    end
    chk("wait_pixel", {31'd0, de}, 32'd1);
  endtask

  // Measures one frame starting on a frame_start cycle; checks period and counts.
  task automatic measure_frame(input string tag);
    int n = 0, de_n = 0, hs_n = 1, vs_n = 1, first_de = -1, max_x = 0, max_y = 0;
    chk({tag, "_fs_now"}, {31'd0, frame_start}, 32'd1);
    do begin
      tick(); n++;
      if (!frame_start) begin
        if (de) begin
          de_n++;
          if (first_de < 0) first_de = n;
          if (int'(active_x) > max_x) max_x = int'(active_x);
          if (int'(active_y) > max_y) max_y = int'(active_y);
        end
        if (hs == 1'b0) hs_n++;
        if (vs == 1'b1) vs_n++;
      end
    end while (!frame_start && n < 2 * FRAME);
    chk({tag, "_period"},   32'(n),        32'(FRAME));
    chk({tag, "_de_count"}, 32'(de_n),     32'(HA * VA));
    chk({tag, "_hs_count"}, 32'(hs_n),     32'(HSY * VT));
    chk({tag, "_vs_count"}, 32'(vs_n),     32'(VSY * HT));
    chk({tag, "_first_de"}, 32'(first_de), 32'((VSY + VBP) * HT + HSY + HBP));
    chk({tag, "_max_x"},    32'(max_x),    32'(HA - 1));
    chk({tag, "_max_y"},    32'(max_y),    32'(VA - 1));
  endtask

  initial begin : stimulus
    tbl.push_back('{2'd0, 24'h0, 1, 0, 24'hFFFFFF});
    tbl.push_back('{2'd0, 24'h0, 2, 3, 24'hFFFF00});
    tbl.push_back('{2'd0, 24'h0, 4, 2, 24'h00FFFF});
    tbl.push_back('{2'd0, 24'h0, 6, 1, 24'h00FF00});
    tbl.push_back('{2'd0, 24'h0, 8, 0, 24'hFF00FF});
    tbl.push_back('{2'd0, 24'h0, 10, 4, 24'hFF0000});
    tbl.push_back('{2'd0, 24'h0, 13, 1, 24'h0000FF});
    tbl.push_back('{2'd0, 24'h0, 14, 5, 24'h000000});
    tbl.push_back('{2'd0, 24'h0, 19, 7, 24'h000000});
    tbl.push_back('{2'd1, 24'h0, 4, 1, 24'hFFFFFF});
    tbl.push_back('{2'd1, 24'h0, 5, 1, 24'h000000});
    tbl.push_back('{2'd1, 24'h0, 5, 4, 24'hFFFFFF});
    tbl.push_back('{2'd1, 24'h0, 19, 2, 24'hFFFFFF});
    tbl.push_back('{2'd1, 24'h0, 6, 7, 24'hFFFFFF});
    tbl.push_back('{2'd2, 24'h0, 7, 2, 24'h070707});
    tbl.push_back('{2'd2, 24'h0, 19, 5, 24'h131313});
    tbl.push_back('{2'd3, 24'hA5C30F, 10, 3, 24'hA5C30F});

    // Reset values while held, then frame_start on the first output cycle.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hs", {31'd0, hs}, 32'd1);
    chk("rst_vs", {31'd0, vs}, 32'd0);
    chk("rst_de", {31'd0, de}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_rgb", {8'd0, rgb_r, rgb_g, rgb_b}, 32'd0);
    rst_n = 1'b1;
    tick();
    measure_frame("pwrup");

    // Pattern spot checks from the vector table.
    foreach (tbl[i]) begin
      @(negedge clk);
      mode = tbl[i].m;
      solid_rgb = tbl[i].s;
      wait_fs();
      wait_px(tbl[i].x, tbl[i].y);
      chk($sformatf("pix_m%0d_x%0d_y%0d", tbl[i].m, tbl[i].x, tbl[i].y),
          {8'd0, rgb_r, rgb_g, rgb_b}, {8'd0, tbl[i].exp});
      if (tbl[i].x == HA - 1 && tbl[i].m == 2'd0) begin
        tick();
        chk("rgb_after_last_x", {7'd0, de, rgb_r, rgb_g, rgb_b}, 32'd0);
      end
    end

    // Mid-frame mode change only takes effect at the next frame.
    @(negedge clk);
    mode = 2'd0;
    wait_fs();
    wait_px(0, 4);
    @(negedge clk);
    mode = 2'd3;
    solid_rgb = 24'h123456;
    wait_px(2, 6);
    chk("midframe_keep_bar", {8'd0, rgb_r, rgb_g, rgb_b}, 32'h00FFFF00);
    wait_fs();
    wait_px(2, 1);
    chk("next_frame_solid", {8'd0, rgb_r, rgb_g, rgb_b}, 32'h00123456);

    // One-clock reset pulse mid-frame; timing restarts as at power-up.
    @(negedge clk);
    mode = 2'd0;
    wait_px(3, 4);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("midrst_de", {31'd0, de}, 32'd0);
    chk("midrst_hs", {31'd0, hs}, 32'd1);
    chk("midrst_vs", {31'd0, vs}, 32'd0);
    chk("midrst_xy", {8'd0, active_x, active_y}, 32'd0);
    chk("midrst_rgb", {8'd0, rgb_r, rgb_g, rgb_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    measure_frame("rerun");

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
